// File: rtl/multdiv_pkg.sv
// Shared constants for the iterative signed multiply/divide unit.
package multdiv_pkg;
    localparam int ITER_COUNT      = 32;
    localparam int MULTDIV_LATENCY = 33;
    localparam int CNT_W           = 6;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MULT = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER_COUNT - 1);
endpackage

// File: rtl/twos_negate.sv
// 32-bit conditional two's-complement negate; with neg_i = sign bit it yields |a|.
module twos_negate (
    input  logic [31:0] a_i,
    input  logic        neg_i,
    output logic [31:0] y_o
);
    assign y_o = neg_i ? (~a_i + 32'd1) : a_i;
endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed multiply (shift-add) and divide (restoring), one bit per cycle,
// working on operand magnitudes with a sign fix on the way out.
module multdiv_unit
    import multdiv_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ctrl_mult,
    input  logic        ctrl_div,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic        busy
);
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [63:0]      acc_q, acc_d;
    logic [63:0]      mcand_q, mcand_d;
    logic [31:0]      opb_q, opb_d;
    logic             neg_q, neg_d;
    logic             is_mult_q, is_mult_d;
    logic             div0_q, div0_d;
    logic             ovf_q, ovf_d;
    logic [31:0]      result_q, result_d;
    logic             exc_q, exc_d;
    logic             rdy_q, rdy_d;

    logic [31:0] abs_a, abs_b, fixed_lo;
    logic [64:0] sh;
    logic [32:0] trial;
    logic        mult_ovf;

    twos_negate u_abs_a (.a_i(data_operandA), .neg_i(data_operandA[31]), .y_o(abs_a));
    twos_negate u_abs_b (.a_i(data_operandB), .neg_i(data_operandB[31]), .y_o(abs_b));
    // Both product low word and quotient live in acc_q[31:0]
    twos_negate u_fix   (.a_i(acc_q[31:0]),   .neg_i(neg_q),             .y_o(fixed_lo));

    // Magnitude product must fit the signed 32-bit range for the result sign
    assign mult_ovf = neg_q ? (acc_q > 64'h0000_0000_8000_0000)
                            : (acc_q > 64'h0000_0000_7FFF_FFFF);

    // Restoring step: shift {rem, dividend} left, try subtracting the divisor
    assign sh    = {acc_q, 1'b0};
    assign trial = sh[64:32] - {1'b0, opb_q};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        opb_d     = opb_q;
        neg_d     = neg_q;
        is_mult_d = is_mult_q;
        div0_d    = div0_q;
        ovf_d     = ovf_q;
        result_d  = result_q;
        exc_d     = exc_q;
        rdy_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ctrl_mult ^ ctrl_div) begin
                    cnt_d     = '0;
                    neg_d     = data_operandA[31] ^ data_operandB[31];
                    is_mult_d = ctrl_mult;
                    opb_d     = abs_b;
                    div0_d    = ctrl_div && (data_operandB == 32'd0);
                    ovf_d     = ctrl_div && (data_operandA == 32'h8000_0000)
                                         && (data_operandB == 32'hFFFF_FFFF);
                    if (ctrl_mult) begin
                        acc_d   = '0;
                        mcand_d = {32'd0, abs_a};
                        state_d = ST_MULT;
                    end else begin
                        acc_d   = {32'd0, abs_a};
                        mcand_d = '0;
                        state_d = (data_operandB == 32'd0) ? ST_DONE : ST_DIV;
                    end
                end
            end
            ST_MULT: begin
                acc_d   = acc_q + (opb_q[0] ? mcand_q : 64'd0);
                mcand_d = {mcand_q[62:0], 1'b0};
                opb_d   = {1'b0, opb_q[31:1]};
                cnt_d   = cnt_q + 6'd1;
                if (cnt_q == LAST_ITER) state_d = ST_DONE;
            end
            ST_DIV: begin
                acc_d = trial[32] ? sh[63:0] : {trial[31:0], sh[31:1], 1'b1};
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == LAST_ITER) state_d = ST_DONE;
            end
            default: begin
                rdy_d    = 1'b1;
                result_d = div0_q ? 32'd0 : fixed_lo;
                exc_d    = div0_q | (is_mult_q ? mult_ovf : ovf_q);
                state_d  = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            opb_q     <= '0;
            neg_q     <= 1'b0;
            is_mult_q <= 1'b0;
            div0_q    <= 1'b0;
            ovf_q     <= 1'b0;
            result_q  <= '0;
            exc_q     <= 1'b0;
            rdy_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            opb_q     <= opb_d;
            neg_q     <= neg_d;
            is_mult_q <= is_mult_d;
            div0_q    <= div0_d;
            ovf_q     <= ovf_d;
            result_q  <= result_d;
            exc_q     <= exc_d;
            rdy_q     <= rdy_d;
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
    assign busy           = (state_q == ST_MULT) || (state_q == ST_DIV);
endmodule

// File: tb/tb_multdiv_unit.sv
// Scoreboard bench for multdiv_unit: expectations are queued at issue and popped at RDY.
module tb_multdiv_unit;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        ctrl_mult = 1'b0, ctrl_div = 1'b0;
    logic [31:0] data_operandA = '0, data_operandB = '0;
    logic [31:0] data_result;
    logic        data_exception, data_resultRDY, busy;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          lat;
    } exp_t;
    exp_t sbq[$];

    multdiv_unit dut (
        .clock(clock), .reset_n(reset_n),
        .ctrl_mult(ctrl_mult), .ctrl_div(ctrl_div),
        .data_operandA(data_operandA), .data_operandB(data_operandB),
        .data_result(data_result), .data_exception(data_exception),
        .data_resultRDY(data_resultRDY), .busy(busy)
    );

    always #5 clock = ~clock;

    function automatic exp_t model(input logic m, input logic [31:0] a, input logic [31:0] b);
        exp_t   x;
        longint p;
        int     q;
        x.lat = 33;
        if (m) begin
            p     = longint'(signed'(a)) * longint'(signed'(b));
            x.res = p[31:0];
            x.exc = (p != longint'(signed'(p[31:0])));
        end else if (b == 32'd0) begin
            x.res = 32'd0; x.exc = 1'b1; x.lat = 1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            x.res = 32'h8000_0000; x.exc = 1'b1;
        end else begin
            q     = signed'(a) / signed'(b);
            x.res = q;
            x.exc = 1'b0;
        end
        return x;
    endfunction

    // Called just after an edge; the next edge samples the start.
    task automatic issue(input logic m, input logic [31:0] a, input logic [31:0] b);
        sbq.push_back(model(m, a, b));
        ctrl_mult = m; ctrl_div = !m;
        data_operandA = a; data_operandB = b;
        @(posedge clock); #1;
        ctrl_mult = 1'b0; ctrl_div = 1'b0;
    endtask

    // lat counts edges after the start edge until RDY is seen (-1 on timeout).
    task automatic wait_rdy(output int lat, output int busy_n, output logic [31:0] r, output logic e);
        bit done = 0;
        lat = -1; r = 'x; e = 1'bx;
        busy_n = busy ? 1 : 0;
        for (int k = 1; k <= 200 && !done; k++) begin
            @(posedge clock); #1;
            if (data_resultRDY) begin
                lat = k; r = data_result; e = data_exception; done = 1;
            end else if (busy) busy_n++;
        end
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if (busy !== 1'b0 || data_resultRDY !== 1'b0 || data_result !== 32'd0 || data_exception !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: busy=%b rdy=%b res=%h exc=%b, want all 0",
                     busy, data_resultRDY, data_result, data_exception);
        end
        @(negedge clock); reset_n = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_mult_basic;
        int lat, bn; logic [31:0] r; logic e; exp_t x;
        issue(1'b1, 32'd6, 32'd7);
        wait_rdy(lat, bn, r, e);
        x = sbq.pop_front();
        checks++;
        if (r !== 32'd42 || r !== x.res || e !== x.exc) begin
            failures++; $display("FAIL mult_6x7: res=%h exc=%b want res=%h exc=%b", r, e, x.res, x.exc);
        end
        checks++;
        if (lat !== x.lat) begin failures++; $display("FAIL mult_latency: got %0d want %0d", lat, x.lat); end
        checks++;
        if (bn !== 32) begin failures++; $display("FAIL mult_busy_cycles: got %0d want 32", bn); end
        @(posedge clock); #1;
        checks++;
        if (data_resultRDY !== 1'b0) begin failures++; $display("FAIL rdy_pulse: rdy=%b want 0", data_resultRDY); end
        repeat (3) @(posedge clock); #1;
        checks++;
        if (data_result !== 32'd42 || data_exception !== 1'b0) begin
            failures++; $display("FAIL result_hold: res=%h exc=%b want 0000002a 0", data_result, data_exception);
        end
    endtask

    task automatic test_div_neg;
        int lat, bn; logic [31:0] r; logic e; exp_t x;
        issue(1'b0, 32'hFFFF_FFF9, 32'd2);
        wait_rdy(lat, bn, r, e);
        x = sbq.pop_front();
        checks++;
        if (r !== 32'hFFFF_FFFD || e !== 1'b0 || lat !== 33 || x.res !== r) begin
            failures++; $display("FAIL div_m7_2: res=%h exc=%b lat=%0d want fffffffd 0 33", r, e, lat);
        end
    endtask

    task automatic test_div_edge;
        int lat, bn; logic [31:0] r; logic e; exp_t x;
        issue(1'b0, 32'd5, 32'd0);
        wait_rdy(lat, bn, r, e);
        x = sbq.pop_front();
        checks++;
        if (r !== 32'd0 || e !== 1'b1 || lat !== 1 || x.lat !== lat) begin
            failures++; $display("FAIL div_by_zero: res=%h exc=%b lat=%0d want 0 1 1", r, e, lat);
        end
        issue(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_rdy(lat, bn, r, e);
        x = sbq.pop_front();
        checks++;
        if (r !== 32'h8000_0000 || e !== 1'b1 || lat !== 33) begin
            failures++; $display("FAIL div_overflow: res=%h exc=%b lat=%0d want 80000000 1 33", r, e, lat);
        end
    endtask

    task automatic test_mult_ovf;
        int lat, bn; logic [31:0] r; logic e; exp_t x;
        issue(1'b1, 32'h0001_0000, 32'h0001_0000);
        wait_rdy(lat, bn, r, e);
        x = sbq.pop_front();
        checks++;
        if (r !== 32'd0 || e !== 1'b1 || lat !== x.lat) begin
            failures++; $display("FAIL mult_overflow: res=%h exc=%b lat=%0d want 0 1 33", r, e, lat);
        end
    endtask

    task automatic test_ignore_ctrl;
        int lat, bn; logic [31:0] r; logic e; exp_t x;
        issue(1'b1, 32'hFFFF_FFFD, 32'd1234567);
        repeat (4) @(posedge clock); #1;
        ctrl_div = 1'b1; data_operandA = 32'd100; data_operandB = 32'd0;
        @(posedge clock); #1;
        ctrl_div = 1'b0;
        wait_rdy(lat, bn, r, e);
        x = sbq.pop_front();
        checks++;
        if (r !== x.res || e !== x.exc || lat + 5 !== 33) begin
            failures++; $display("FAIL ignore_ctrl: res=%h exc=%b lat=%0d want %h %b 33", r, e, lat + 5, x.res, x.exc);
        end
    endtask

    task automatic test_both_ctrl;
        int bn = 0, rn = 0;
        ctrl_mult = 1'b1; ctrl_div = 1'b1; data_operandA = 32'd3; data_operandB = 32'd4;
        @(posedge clock); #1;
        ctrl_mult = 1'b0; ctrl_div = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (busy) bn++;
            if (data_resultRDY) rn++;
            @(posedge clock); #1;
        end
        checks++;
        if (bn !== 0 || rn !== 0) begin
            failures++; $display("FAIL both_ctrl: busy_cycles=%0d rdy_count=%0d want 0 0", bn, rn);
        end
    endtask

    task automatic test_reset_mid;
        int lat, bn, rn = 0; logic [31:0] r; logic e; exp_t x;
        issue(1'b0, 32'd1000, 32'd7);
        repeat (9) @(posedge clock); #1;
        reset_n = 1'b0; #1;
        checks++;
        if (busy !== 1'b0 || data_resultRDY !== 1'b0 || data_result !== 32'd0 || data_exception !== 1'b0) begin
            failures++; $display("FAIL reset_mid: busy=%b rdy=%b res=%h exc=%b want all 0",
                                 busy, data_resultRDY, data_result, data_exception);
        end
        void'(sbq.pop_back());
        repeat (2) @(posedge clock);
        @(negedge clock); reset_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clock); #1;
            if (data_resultRDY) rn++;
        end
        checks++;
        if (rn !== 0) begin failures++; $display("FAIL reset_no_rdy: rdy_count=%0d want 0", rn); end
        issue(1'b1, 32'hFFFF_FFFB, 32'hFFFF_FFF7);
        wait_rdy(lat, bn, r, e);
        x = sbq.pop_front();
        checks++;
        if (r !== 32'd45 || e !== 1'b0 || lat !== 33 || x.res !== r) begin
            failures++; $display("FAIL mult_after_reset: res=%h exc=%b lat=%0d want 2d 0 33", r, e, lat);
        end
    endtask

    task automatic test_back_to_back;
        int lat, bn; logic [31:0] r; logic e; exp_t x;
        logic m; logic [31:0] a, b;
        for (int i = 0; i < 12; i++) begin
            m = 1'($urandom_range(0, 1));
            a = $urandom;
            b = (i % 3 == 0) ? 32'($urandom_range(0, 9)) - 32'd4 : $urandom;
            if (i % 4 == 1) a = a >>> 16;
            issue(m, a, b);
            wait_rdy(lat, bn, r, e);
            x = sbq.pop_front();
            checks++;
            if (r !== x.res || e !== x.exc || lat !== x.lat) begin
                failures++;
                $display("FAIL back_to_back[%0d] %s a=%h b=%h: res=%h exc=%b lat=%0d want %h %b %0d",
                         i, m ? "mul" : "div", a, b, r, e, lat, x.res, x.exc, x.lat);
            end
        end
    endtask

    initial begin
        test_reset;
        test_mult_basic;
        test_div_neg;
        test_div_edge;
        test_mult_ovf;
        test_ignore_ctrl;
        test_both_ctrl;
        test_reset_mid;
        test_back_to_back;
        checks++;
        if (sbq.size() !== 0) begin failures++; $display("FAIL scoreboard_drain: %0d left want 0", sbq.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/multdiv_unit.md
MULTDIV_UNIT -- requirements
Module: multdiv_unit

Interface
REQ-001 SHALL have port clock, input, 1, single rising-edge clock for all state.
REQ-002 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port ctrl_mult, input, 1, start signed multiply; driven by the execute-stage mult decode.
REQ-004 SHALL have port ctrl_div, input, 1, start signed divide; driven by the execute-stage div decode.
REQ-005 SHALL have port data_operandA, input, 32, multiplicand or dividend.
REQ-006 SHALL have port data_operandB, input, 32, multiplier or divisor.
REQ-007 SHALL have port data_result, output, 32, product low word or quotient.
REQ-008 SHALL have port data_exception, output, 1, overflow or divide-by-zero flag, valid with data_resultRDY.
REQ-009 SHALL have port data_resultRDY, output, 1, one-cycle pulse marking a valid result.
REQ-010 SHALL have port busy, output, 1, pipeline stall request.

Function
REQ-011 SHALL implement FSM states IDLE, MULT, DIV, DONE.
REQ-012 SHALL, in IDLE on a rising edge with exactly one of ctrl_mult/ctrl_div high, latch both operands and operation, clear the iteration counter, and go to MULT or DIV.
REQ-013 SHALL treat ctrl_mult and ctrl_div high together as no operation and stay in IDLE.
REQ-014 SHALL ignore ctrl_mult/ctrl_div outside IDLE; latched operands are unaffected.
REQ-015 SHALL multiply on operand magnitudes with 32 shift-add iterations into a 64-bit accumulator, one per cycle, negating the result when operand signs differ.
REQ-016 SHALL divide on operand magnitudes with 32 restoring iterations, one per cycle, quotient truncated toward zero and negated when signs differ; no remainder output.
REQ-017 SHALL go to DONE after the 32nd iteration, so that for a start sampled at edge N, data_resultRDY is high only between edges N+33 and N+34.
REQ-018 SHALL, when divisor is 0 at start, go directly to DONE, giving data_resultRDY between edges N+1 and N+2, data_result 0 and data_exception 1.
REQ-019 SHALL, for dividend 0x80000000 and divisor 0xFFFFFFFF, return data_result 0x80000000 and data_exception 1 with normal latency.
REQ-020 SHALL set data_exception 1 on multiply when the signed 64-bit product is not the sign extension of its low 32 bits; data_result SHALL still be the low 32 bits.
REQ-021 SHALL assert busy in MULT and DIV only; busy SHALL be low in IDLE and DONE so the pipeline advances with the result.
REQ-022 SHALL hold data_result and data_exception from DONE until the next DONE.
REQ-023 SHALL return DONE to IDLE unconditionally after one cycle; a start is accepted from the edge after DONE.

Reset
REQ-024 SHALL, on reset_n low, asynchronously force state IDLE and set counter, accumulators, data_result, data_exception, data_resultRDY and busy to 0.
REQ-025 SHALL abandon any operation in flight on reset mid-operation and produce no data_resultRDY for it.
REQ-026 SHALL leave reset synchronously to clock, with first start accepted on the first edge after release.

Structure
REQ-027 SHALL place state encoding, ITER_COUNT=32 and MULTDIV_LATENCY=33 in shared package multdiv_pkg.
REQ-028 SHALL use one combinational sub-module, twos_negate, for 32-bit conditional negate/abs, instanced for operand magnitudes and result sign fix.

Verification
REQ-029 SHALL cover: ctrl_mult, A=6, B=7 -> data_resultRDY exactly 33 cycles after start, result 42, exception 0, busy high 32 cycles.
REQ-030 SHALL cover: ctrl_div, A=-7, B=2 -> result 0xFFFFFFFD, exception 0, 33-cycle latency.
REQ-031 SHALL cover: ctrl_div, A=5, B=0 -> result 0, exception 1, RDY one cycle after start; then 0x80000000/0xFFFFFFFF -> 0x80000000, exception 1.
REQ-032 SHALL cover: ctrl_mult, A=0x00010000, B=0x00010000 -> result 0, exception 1.
REQ-033 SHALL cover: ctrl_div pulsed at cycle 5 of a multiply -> ignored, multiply result unchanged; both ctrls high in IDLE -> no busy, no RDY.
REQ-034 SHALL cover: reset_n low at cycle 10 of a divide -> busy and all outputs 0 immediately, no RDY; a new multiply after release completes correctly.
